z80fi_insn_collector: RTL

//  Upstream of the z80fi_insn_spec_* checkers. Watches per-cycle trace strobes from the core.

---
 rtl/z80fi_insn_collector_if.sv | 62 ++++++
 rtl/z80fi_insn_collector.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80fi_insn_collector_if.sv
// ---------------------------------------------------------------------------
// z80fi_insn_collector_if
// Groups the core trace strobes and the retired-instruction record.
//   master : trace source (core or bench). Drives the insn_*, reg1_* and
//            mem_* strobes, and reads the z80fi_* record.
//   slave  : collector. Reads the strobes and drives the z80fi_* record.
// When Z80FI_MEM_RD2_EN is defined, the second-memory-read fields are present:
//   z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2.
// ---------------------------------------------------------------------------
interface z80fi_insn_collector_if;
  // trace strobes from the core
  logic        insn_start;
  logic [15:0] insn_pc;
  logic        insn_byte_valid;
  logic [7:0]  insn_byte;
  logic        insn_done;
  logic        reg1_valid;
  logic [3:0]  reg1_rnum;
  logic [15:0] reg1_rdata;
  logic        mem_rd_valid;
  logic [15:0] mem_raddr;
  logic [7:0]  mem_rdata;
  // retired instruction record
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] z80fi_pc_rdata;
  logic [3:0]  z80fi_reg1_rnum;
  logic [15:0] z80fi_reg1_rdata;
  logic [15:0] z80fi_mem_raddr;
  logic [7:0]  z80fi_mem_rdata;
  logic        z80fi_err;
`ifdef Z80FI_MEM_RD2_EN
  logic        z80fi_mem_rd2;
  logic [15:0] z80fi_mem_raddr2;
  logic [7:0]  z80fi_mem_rdata2;
`endif

  modport master (
    output insn_start, insn_pc, insn_byte_valid, insn_byte, insn_done,
    output reg1_valid, reg1_rnum, reg1_rdata,
    output mem_rd_valid, mem_raddr, mem_rdata,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
    input  z80fi_reg1_rnum, z80fi_reg1_rdata, z80fi_mem_raddr, z80fi_mem_rdata,
    input  z80fi_err
`ifdef Z80FI_MEM_RD2_EN
    , input z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2
`endif
  );

  modport slave (
    input  insn_start, insn_pc, insn_byte_valid, insn_byte, insn_done,
    input  reg1_valid, reg1_rnum, reg1_rdata,
    input  mem_rd_valid, mem_raddr, mem_rdata,
    output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
    output z80fi_reg1_rnum, z80fi_reg1_rdata, z80fi_mem_raddr, z80fi_mem_rdata,
    output z80fi_err
`ifdef Z80FI_MEM_RD2_EN
    , output z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2
`endif
  );
endinterface

// File: rtl/z80fi_insn_collector.sv
// ---------------------------------------------------------------------------
// z80fi_insn_collector
// Watches the per-cycle trace strobes of a Z80 core and assembles one
// retired-instruction record per instruction. The record holds:
//   - the instruction bytes, with byte k at [8k+7:8k], and the byte count
//   - the PC
//   - the first register-1 read and the first memory read
// The record is presented with a one-cycle z80fi_valid pulse.
// Ports:
//   clk     : sole clock; all state changes on its rising edge
//   reset_n : asynchronous active-low reset
//   bus     : z80fi_insn_collector_if.slave (trace strobes in, record out)
// Parameter MAX_LEN : number of instruction bytes; must be 4 (z80fi_insn is 32 bits).
// Optional feature macro Z80FI_MEM_RD2_EN : also captures the second memory
// read of an instruction. With this macro, a third or later read sets z80fi_err.
// ---------------------------------------------------------------------------
module z80fi_insn_collector #(
  parameter int MAX_LEN = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  z80fi_insn_collector_if.slave   bus
);

  localparam logic [2:0] MAX_LEN_C = 3'(MAX_LEN);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OPEN = 1'b1} state_t;

  state_t      state_r;

  // working copy of the instruction being collected
  logic [31:0] insn_r;
  logic [2:0]  len_r;
  logic [15:0] pc_r;
  logic        reg1_cap_r;
  logic [3:0]  reg1_rnum_r;
  logic [15:0] reg1_rdata_r;
  logic        mem_cap_r;
  logic [15:0] mem_raddr_r;
  logic [7:0]  mem_rdata_r;
`ifdef Z80FI_MEM_RD2_EN
  logic        mem2_cap_r;
  logic [15:0] mem_raddr2_r;
  logic [7:0]  mem_rdata2_r;
`endif

  // base = working copy, or a blank record when this cycle opens a new instruction
  logic [31:0] base_insn_s;
  logic [2:0]  base_len_s;
  logic [15:0] base_pc_s;
  logic        base_reg1_cap_s;
  logic [3:0]  base_reg1_rnum_s;
  logic [15:0] base_reg1_rdata_s;
  logic        base_mem_cap_s;
  logic [15:0] base_mem_raddr_s;
  logic [7:0]  base_mem_rdata_s;
  // nxt = base with this cycle's byte/capture strobes merged in
  logic [31:0] nxt_insn_s;
  logic [2:0]  nxt_len_s;
  logic        nxt_reg1_cap_s;
  logic [3:0]  nxt_reg1_rnum_s;
  logic [15:0] nxt_reg1_rdata_s;
  logic        nxt_mem_cap_s;
  logic [15:0] nxt_mem_raddr_s;
  logic [7:0]  nxt_mem_rdata_s;
  logic        strobe_err_s;
  logic        load_en_s;
  // record published if this cycle retires
  logic [31:0] ret_insn_s;
  logic [2:0]  ret_len_s;
  logic [15:0] ret_pc_s;
  logic [3:0]  ret_reg1_rnum_s;
  logic [15:0] ret_reg1_rdata_s;
  logic [15:0] ret_mem_raddr_s;
  logic [7:0]  ret_mem_rdata_s;
`ifdef Z80FI_MEM_RD2_EN
  logic        base_mem2_cap_s;
  logic [15:0] base_mem_raddr2_s;
  logic [7:0]  base_mem_rdata2_s;
  logic        nxt_mem2_cap_s;
  logic [15:0] nxt_mem_raddr2_s;
  logic [7:0]  nxt_mem_rdata2_s;
  logic        ret_mem2_cap_s;
  logic [15:0] ret_mem_raddr2_s;
  logic [7:0]  ret_mem_rdata2_s;
`endif

  // Merge this cycle's strobes into the right instruction and select the retire record
  always_comb begin
    if (bus.insn_start) begin
      // strobes in a start cycle belong to the new instruction
      base_insn_s       = 32'h0000_0000;
      base_len_s        = 3'd0;
      base_pc_s         = bus.insn_pc;
      base_reg1_cap_s   = 1'b0;
      base_reg1_rnum_s  = 4'h0;
      base_reg1_rdata_s = 16'h0000;
      base_mem_cap_s    = 1'b0;
      base_mem_raddr_s  = 16'h0000;
      base_mem_rdata_s  = 8'h00;
    end else begin
      base_insn_s       = insn_r;
      base_len_s        = len_r;
      base_pc_s         = pc_r;
      base_reg1_cap_s   = reg1_cap_r;
      base_reg1_rnum_s  = reg1_rnum_r;
      base_reg1_rdata_s = reg1_rdata_r;
      base_mem_cap_s    = mem_cap_r;
      base_mem_raddr_s  = mem_raddr_r;
      base_mem_rdata_s  = mem_rdata_r;
    end

    nxt_insn_s   = base_insn_s;
    strobe_err_s = 1'b0;
    if (bus.insn_byte_valid && (base_len_s == MAX_LEN_C)) begin
      // buffer full: byte dropped, flagged as a protocol error
      nxt_len_s    = base_len_s;
      strobe_err_s = 1'b1;
    end else if (bus.insn_byte_valid) begin
      nxt_insn_s[{base_len_s[1:0], 3'b000} +: 8] = bus.insn_byte;
      nxt_len_s = base_len_s + 3'd1;
    end else begin
      nxt_len_s = base_len_s;
    end

    if (bus.reg1_valid && !base_reg1_cap_s) begin
      nxt_reg1_cap_s   = 1'b1;
      nxt_reg1_rnum_s  = bus.reg1_rnum;
      nxt_reg1_rdata_s = bus.reg1_rdata;
    end else begin
      nxt_reg1_cap_s   = base_reg1_cap_s;
      nxt_reg1_rnum_s  = base_reg1_rnum_s;
      nxt_reg1_rdata_s = base_reg1_rdata_s;
    end

    if (bus.mem_rd_valid && !base_mem_cap_s) begin
      nxt_mem_cap_s   = 1'b1;
      nxt_mem_raddr_s = bus.mem_raddr;
      nxt_mem_rdata_s = bus.mem_rdata;
    end else begin
      nxt_mem_cap_s   = base_mem_cap_s;
      nxt_mem_raddr_s = base_mem_raddr_s;
      nxt_mem_rdata_s = base_mem_rdata_s;
    end

`ifdef Z80FI_MEM_RD2_EN
    if (bus.insn_start) begin
      base_mem2_cap_s   = 1'b0;
      base_mem_raddr2_s = 16'h0000;
      base_mem_rdata2_s = 8'h00;
    end else begin
      base_mem2_cap_s   = mem2_cap_r;
      base_mem_raddr2_s = mem_raddr2_r;
      base_mem_rdata2_s = mem_rdata2_r;
    end
    if (bus.mem_rd_valid && base_mem_cap_s && !base_mem2_cap_s) begin
      nxt_mem2_cap_s   = 1'b1;
      nxt_mem_raddr2_s = bus.mem_raddr;
      nxt_mem_rdata2_s = bus.mem_rdata;
    end else begin
      nxt_mem2_cap_s   = base_mem2_cap_s;
      nxt_mem_raddr2_s = base_mem_raddr2_s;
      nxt_mem_rdata2_s = base_mem_rdata2_s;
    end
    if (bus.mem_rd_valid && base_mem_cap_s && base_mem2_cap_s) begin
      strobe_err_s = 1'b1;   // third or later data read
    end else begin
      strobe_err_s = strobe_err_s;
    end
`endif

    // With start+done, the closing instruction excludes this cycle's strobes
    if (bus.insn_start) begin
      ret_insn_s       = insn_r;
      ret_len_s        = len_r;
      ret_pc_s         = pc_r;
      ret_reg1_rnum_s  = reg1_rnum_r;
      ret_reg1_rdata_s = reg1_rdata_r;
      ret_mem_raddr_s  = mem_raddr_r;
      ret_mem_rdata_s  = mem_rdata_r;
    end else begin
      ret_insn_s       = nxt_insn_s;
      ret_len_s        = nxt_len_s;
      ret_pc_s         = base_pc_s;
      ret_reg1_rnum_s  = nxt_reg1_rnum_s;
      ret_reg1_rdata_s = nxt_reg1_rdata_s;
      ret_mem_raddr_s  = nxt_mem_raddr_s;
      ret_mem_rdata_s  = nxt_mem_rdata_s;
    end
`ifdef Z80FI_MEM_RD2_EN
    if (bus.insn_start) begin
      ret_mem2_cap_s   = mem2_cap_r;
      ret_mem_raddr2_s = mem_raddr2_r;
      ret_mem_rdata2_s = mem_rdata2_r;
    end else begin
      ret_mem2_cap_s   = nxt_mem2_cap_s;
      ret_mem_raddr2_s = nxt_mem_raddr2_s;
      ret_mem_rdata2_s = nxt_mem_rdata2_s;
    end
`endif

    // working copy advances when an instruction opens or keeps collecting
    if (state_r == ST_OPEN) begin
      load_en_s = bus.insn_start | ~bus.insn_done;
    end else begin
      load_en_s = bus.insn_start;
    end
  end

  // Working copy of the instruction under collection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      insn_r       <= 32'h0000_0000;
      len_r        <= 3'd0;
      pc_r         <= 16'h0000;
      reg1_cap_r   <= 1'b0;
      reg1_rnum_r  <= 4'h0;
      reg1_rdata_r <= 16'h0000;
      mem_cap_r    <= 1'b0;
      mem_raddr_r  <= 16'h0000;
      mem_rdata_r  <= 8'h00;
`ifdef Z80FI_MEM_RD2_EN
      mem2_cap_r   <= 1'b0;
      mem_raddr2_r <= 16'h0000;
      mem_rdata2_r <= 8'h00;
`endif
    end else if (load_en_s) begin
      insn_r       <= nxt_insn_s;
      len_r        <= nxt_len_s;
      pc_r         <= base_pc_s;
      reg1_cap_r   <= nxt_reg1_cap_s;
      reg1_rnum_r  <= nxt_reg1_rnum_s;
      reg1_rdata_r <= nxt_reg1_rdata_s;
      mem_cap_r    <= nxt_mem_cap_s;
      mem_raddr_r  <= nxt_mem_raddr_s;
      mem_rdata_r  <= nxt_mem_rdata_s;
`ifdef Z80FI_MEM_RD2_EN
      mem2_cap_r   <= nxt_mem2_cap_s;
      mem_raddr2_r <= nxt_mem_raddr2_s;
      mem_rdata2_r <= nxt_mem_rdata2_s;
`endif
    end else begin
      insn_r <= insn_r;
    end
  end

  // Collector FSM, retire record and sticky protocol error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r              <= ST_IDLE;
      bus.z80fi_valid      <= 1'b0;
      bus.z80fi_insn       <= 32'h0000_0000;
      bus.z80fi_insn_len   <= 3'd0;
      bus.z80fi_pc_rdata   <= 16'h0000;
      bus.z80fi_reg1_rnum  <= 4'h0;
      bus.z80fi_reg1_rdata <= 16'h0000;
      bus.z80fi_mem_raddr  <= 16'h0000;
      bus.z80fi_mem_rdata  <= 8'h00;
      bus.z80fi_err        <= 1'b0;
`ifdef Z80FI_MEM_RD2_EN
      bus.z80fi_mem_rd2    <= 1'b0;
      bus.z80fi_mem_raddr2 <= 16'h0000;
      bus.z80fi_mem_rdata2 <= 8'h00;
`endif
    end else begin
      bus.z80fi_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // done with nothing open, or a byte with nothing to land in
          if (bus.insn_done || (bus.insn_byte_valid && !bus.insn_start) ||
              (bus.insn_start && strobe_err_s)) begin
            bus.z80fi_err <= 1'b1;
          end else begin
            bus.z80fi_err <= bus.z80fi_err;
          end
          if (bus.insn_start) begin
            state_r <= ST_OPEN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_OPEN: begin
          if (bus.insn_done && (ret_len_s != 3'd0)) begin
            bus.z80fi_valid      <= 1'b1;
            bus.z80fi_insn       <= ret_insn_s;
            bus.z80fi_insn_len   <= ret_len_s;
            bus.z80fi_pc_rdata   <= ret_pc_s;
            bus.z80fi_reg1_rnum  <= ret_reg1_rnum_s;
            bus.z80fi_reg1_rdata <= ret_reg1_rdata_s;
            bus.z80fi_mem_raddr  <= ret_mem_raddr_s;
            bus.z80fi_mem_rdata  <= ret_mem_rdata_s;
`ifdef Z80FI_MEM_RD2_EN
            bus.z80fi_mem_rd2    <= ret_mem2_cap_s;
            bus.z80fi_mem_raddr2 <= ret_mem_raddr2_s;
            bus.z80fi_mem_rdata2 <= ret_mem_rdata2_s;
`endif
          end else begin
            bus.z80fi_valid <= 1'b0;
          end
          // empty retire, abort (start without done), or a strobe error
          if ((bus.insn_done && (ret_len_s == 3'd0)) ||
              (bus.insn_start && !bus.insn_done) || strobe_err_s) begin
            bus.z80fi_err <= 1'b1;
          end else begin
            bus.z80fi_err <= bus.z80fi_err;
          end
          if (bus.insn_done && !bus.insn_start) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_OPEN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
